// File: rtl/imem_fetch_arbiter.sv
// Two-requester arbiter for the single-port, 1-cycle-latency instruction memory.
// The CPU fetch stage issues byte PCs and the debug/trace port issues word addresses.
// At most one read is outstanding at a time. The memory read data is passed through
// to whichever port owns the outstanding response. The CPU normally has priority, but
// debug is forced through after MAX_CPU_STREAK consecutive CPU wins while debug waits.
module imem_fetch_arbiter #(
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 32,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU fetch request/response
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [31:0]       cpu_req_pc,
  output logic              cpu_rsp_valid,
  input  logic              cpu_rsp_ready,
  output logic [DATA_W-1:0] cpu_rsp_data,
  output logic              cpu_rsp_err,
  // Debug read request/response
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [DATA_W-1:0] dbg_rsp_data,
  // Instruction memory
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout
);

  // Which port, if any, owns the single outstanding response.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_RSP = 2'd1,
    ST_DBG_RSP = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_CPU_STREAK);

  state_t      state_reg, state_next;
  logic        err_reg, err_next;
  logic [3:0]  streak_reg, streak_next;

  logic              cpu_err;
  logic [ADDR_W-1:0] cpu_word;
  logic              rsp_hs;
  logic              blocked;
  logic              dbg_wins;
  logic              cpu_gnt;
  logic              dbg_gnt;

  // Validate the CPU byte PC and extract its word address.
  always_comb begin
    cpu_err  = (|cpu_req_pc[1:0]) || (|cpu_req_pc[31:ADDR_W+2]);
    cpu_word = cpu_req_pc[ADDR_W+1:2];
  end

  // Arbitration, response routing and next-state logic.
  always_comb begin
    cpu_req_ready = 1'b0;
    dbg_req_ready = 1'b0;
    cpu_rsp_valid = 1'b0;
    dbg_rsp_valid = 1'b0;
    cpu_rsp_data  = '0;
    cpu_rsp_err   = 1'b0;
    dbg_rsp_data  = '0;
    mem_en        = 1'b0;
    mem_addr      = '0;
    state_next    = state_reg;
    err_next      = err_reg;
    streak_next   = streak_reg;
    dbg_wins      = 1'b0;
    cpu_gnt       = 1'b0;
    dbg_gnt       = 1'b0;

    // Responses are presented straight from the memory output register. mem_dout stays
    // stable while a response is held because no new read is issued until it drains.
    if (rst_n && state_reg == ST_CPU_RSP) begin
      cpu_rsp_valid = 1'b1;
      cpu_rsp_err   = err_reg;
      cpu_rsp_data  = err_reg ? '0 : mem_dout;
    end
    if (rst_n && state_reg == ST_DBG_RSP) begin
      dbg_rsp_valid = 1'b1;
      dbg_rsp_data  = mem_dout;
    end

    rsp_hs  = (cpu_rsp_valid && cpu_rsp_ready) || (dbg_rsp_valid && dbg_rsp_ready);
    blocked = (state_reg != ST_IDLE) && !rsp_hs;

    // The CPU wins by default. Debug takes over when the CPU is idle, or when it has
    // been starved for STREAK_LIMIT consecutive CPU grants.
    dbg_wins = dbg_req_valid && (!cpu_req_valid || (streak_reg >= STREAK_LIMIT));
    cpu_gnt  = rst_n && !blocked && cpu_req_valid && !dbg_wins;
    dbg_gnt  = rst_n && !blocked && dbg_wins;

    cpu_req_ready = cpu_gnt;
    dbg_req_ready = dbg_gnt;

    // Errored PCs are accepted and answered, but never touch the memory.
    if (dbg_gnt) begin
      mem_en   = 1'b1;
      mem_addr = dbg_req_addr;
    end else if (cpu_gnt && !cpu_err) begin
      mem_en   = 1'b1;
      mem_addr = cpu_word;
    end

    if (cpu_gnt) begin
      state_next = ST_CPU_RSP;
      err_next   = cpu_err;
    end else if (dbg_gnt) begin
      state_next = ST_DBG_RSP;
      err_next   = 1'b0;
    end else if (rsp_hs) begin
      state_next = ST_IDLE;
      err_next   = 1'b0;
    end

    // Count CPU wins only while debug is actually waiting. The counter saturates at 15.
    if (!dbg_req_valid || dbg_gnt) begin
      streak_next = 4'd0;
    end else if (cpu_gnt && streak_reg != 4'hF) begin
      streak_next = streak_reg + 4'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      err_reg    <= 1'b0;
      streak_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      err_reg    <= err_next;
      streak_reg <= streak_next;
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a behavioural 2048x32 synchronous-read memory.
module tb_imem_fetch_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic [31:0]       cpu_req_pc;
  logic              cpu_rsp_valid;
  logic              cpu_rsp_ready;
  logic [DATA_W-1:0] cpu_rsp_data;
  logic              cpu_rsp_err;
  logic              dbg_req_valid;
  logic              dbg_req_ready;
  logic [ADDR_W-1:0] dbg_req_addr;
  logic              dbg_rsp_valid;
  logic              dbg_rsp_ready;
  logic [DATA_W-1:0] dbg_rsp_data;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;

  logic [DATA_W-1:0] mem [0:2047];

  int checks = 0;
  int passed = 0;

  imem_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_pc(cpu_req_pc),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_err(cpu_rsp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_addr(dbg_req_addr),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_data(dbg_rsp_data),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model: 1-cycle registered read.
  always @(posedge clk) begin
    if (mem_en) mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // With both requesters held valid, check the grant sequence (bit i = 1 means CPU) and
  // the response for each previous grant. CPU reads PC 0x20 (word 8); debug reads word 100.
  task automatic run_grants(input int n, input logic [15:0] pat, input string tag);
    #1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cpu_rdy"}, cpu_req_ready, pat[i]);
      chk({tag, "_dbg_rdy"}, dbg_req_ready, !pat[i]);
      chk({tag, "_addr"}, mem_addr, pat[i] ? 32'd8 : 32'd100);
      if (i > 0) begin
        if (pat[i-1]) begin
          chk({tag, "_cpu_rsp_v"}, cpu_rsp_valid, 1'b1);
          chk({tag, "_cpu_rsp_d"}, cpu_rsp_data, mem[8]);
        end else begin
          chk({tag, "_dbg_rsp_v"}, dbg_rsp_valid, 1'b1);
          chk({tag, "_dbg_rsp_d"}, dbg_rsp_data, mem[100]);
        end
      end
      $display("%s step %0d: cpu_rdy=%0b dbg_rdy=%0b addr=%0d", tag, i, cpu_req_ready,
               dbg_req_ready, mem_addr);
      tick();
    end
  endtask

  initial begin
    logic [15:0] pat;
    for (int i = 0; i < 2048; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[4] = 32'h2402_000A;

    rst_n = 1'b0;
    cpu_req_valid = 1'b0; cpu_req_pc = '0; cpu_rsp_ready = 1'b0;
    dbg_req_valid = 1'b0; dbg_req_addr = '0; dbg_rsp_ready = 1'b0;
    tick();
    tick();

    // Reset state, including a request held during reset.
    cpu_req_valid = 1'b1; cpu_req_pc = 32'h10;
    #1;
    chk("rst_cpu_rsp_v", cpu_rsp_valid, 1'b0);
    chk("rst_dbg_rsp_v", dbg_rsp_valid, 1'b0);
    chk("rst_err", cpu_rsp_err, 1'b0);
    chk("rst_cpu_rdy", cpu_req_ready, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    $display("reset: rsp_v=%0b rdy=%0b mem_en=%0b", cpu_rsp_valid, cpu_req_ready, mem_en);
    tick();

    // Single CPU fetch of PC 0x10 (word 4).
    rst_n = 1'b1;
    #1;
    chk("f1_rdy", cpu_req_ready, 1'b1);
    chk("f1_mem_en", mem_en, 1'b1);
    chk("f1_addr", mem_addr, 32'd4);
    tick();
    cpu_req_valid = 1'b0;
    #1;
    chk("f1_rsp_v", cpu_rsp_valid, 1'b1);
    chk("f1_rsp_d", cpu_rsp_data, 32'h2402_000A);
    chk("f1_err", cpu_rsp_err, 1'b0);
    chk("f1_dbg_v", dbg_rsp_valid, 1'b0);
    $display("fetch pc=0x10: data=%h", cpu_rsp_data);
    cpu_rsp_ready = 1'b1;
    tick();
    chk("f1_drained", cpu_rsp_valid, 1'b0);

    // Back-to-back fetches of PCs 0x0, 0x4 and 0x8.
    cpu_req_valid = 1'b1; cpu_req_pc = 32'h0;
    #1;
    chk("b2b_addr0", mem_addr, 32'd0);
    tick();
    cpu_req_pc = 32'h4;
    #1;
    chk("b2b_rdy1", cpu_req_ready, 1'b1);
    chk("b2b_addr1", mem_addr, 32'd1);
    chk("b2b_d0", cpu_rsp_data, mem[0]);
    tick();
    cpu_req_pc = 32'h8;
    #1;
    chk("b2b_addr2", mem_addr, 32'd2);
    chk("b2b_d1", cpu_rsp_data, mem[1]);
    tick();
    cpu_req_valid = 1'b0;
    #1;
    chk("b2b_d2", cpu_rsp_data, mem[2]);
    $display("b2b: last data=%h", cpu_rsp_data);
    tick();
    chk("b2b_idle", cpu_rsp_valid, 1'b0);

    // Response stall: three cycles with cpu_rsp_ready low while both ports request.
    cpu_req_valid = 1'b1; cpu_req_pc = 32'hC; cpu_rsp_ready = 1'b0;
    tick();
    cpu_req_pc = 32'h10; dbg_req_valid = 1'b1; dbg_req_addr = 11'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_d", cpu_rsp_data, mem[3]);
      chk("stall_v", cpu_rsp_valid, 1'b1);
      chk("stall_mem_en", mem_en, 1'b0);
      chk("stall_cpu_rdy", cpu_req_ready, 1'b0);
      chk("stall_dbg_rdy", dbg_req_ready, 1'b0);
      $display("stall cycle %0d: data=%h mem_en=%0b", i, cpu_rsp_data, mem_en);
      tick();
    end
    cpu_rsp_ready = 1'b1;
    #1;
    chk("resume_d", cpu_rsp_data, mem[3]);
    chk("resume_cpu_rdy", cpu_req_ready, 1'b1);
    chk("resume_dbg_rdy", dbg_req_ready, 1'b0);
    chk("resume_addr", mem_addr, 32'd4);
    tick();
    cpu_req_valid = 1'b0; dbg_req_valid = 1'b0;
    #1;
    chk("resume_d2", cpu_rsp_data, 32'h2402_000A);
    tick();

    // Streak: with both ports held valid the grant order is C,C,C,C,D,C.
    cpu_req_valid = 1'b1; cpu_req_pc = 32'h20;
    dbg_req_valid = 1'b1; dbg_req_addr = 11'd100; dbg_rsp_ready = 1'b1;
    pat = 16'b10_1111;
    run_grants(6, pat, "streak");
    cpu_req_valid = 1'b0; dbg_req_valid = 1'b0;
    #1;
    chk("streak_last", cpu_rsp_data, mem[8]);
    tick();

    // Address errors and the last valid word.
    cpu_req_valid = 1'b1; cpu_req_pc = 32'h6;
    #1;
    chk("mis_rdy", cpu_req_ready, 1'b1);
    chk("mis_mem_en", mem_en, 1'b0);
    chk("mis_addr", mem_addr, 32'd0);
    tick();
    cpu_req_pc = 32'h2000;
    #1;
    chk("mis_err", cpu_rsp_err, 1'b1);
    chk("mis_d", cpu_rsp_data, 32'h0);
    chk("oor_mem_en", mem_en, 1'b0);
    tick();
    cpu_req_pc = 32'h1FFC;
    #1;
    chk("oor_err", cpu_rsp_err, 1'b1);
    chk("oor_d", cpu_rsp_data, 32'h0);
    chk("top_mem_en", mem_en, 1'b1);
    chk("top_addr", mem_addr, 32'd2047);
    tick();
    cpu_req_valid = 1'b0;
    #1;
    chk("top_err", cpu_rsp_err, 1'b0);
    chk("top_d", cpu_rsp_data, mem[2047]);
    $display("pc=0x1FFC: data=%h err=%0b", cpu_rsp_data, cpu_rsp_err);
    tick();

    // Reset one cycle after a grant, with the streak at 3. The pending response is
    // dropped and arbitration restarts from a zero streak.
    cpu_req_valid = 1'b1; cpu_req_pc = 32'h20;
    dbg_req_valid = 1'b1; dbg_req_addr = 11'd100;
    pat = 16'b111;
    run_grants(3, pat, "pre_rst");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_v", cpu_rsp_valid, 1'b0);
    chk("mid_rst_cpu_rdy", cpu_req_ready, 1'b0);
    chk("mid_rst_dbg_rdy", dbg_req_ready, 1'b0);
    chk("mid_rst_mem_en", mem_en, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_cpu_v", cpu_rsp_valid, 1'b0);
    chk("post_rst_dbg_v", dbg_rsp_valid, 1'b0);
    pat = 16'b10_1111;
    run_grants(6, pat, "post_rst");
    cpu_req_valid = 1'b0; dbg_req_valid = 1'b0;
    #1;
    chk("post_rst_last", cpu_rsp_data, mem[8]);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Shares the single-port, synchronous-read MIPS32SOC instruction memory (2048 x 32, 1-cycle read latency, read enable plus 11-bit word address) between two requesters:
  - the CPU fetch stage, which issues byte PCs;
  - a debug/trace read port, which issues word addresses.
- Drives the memory enable and address, and routes the registered read data back to the requester that issued the read.
- Uses valid/ready handshakes on both sides.
- Rejects misaligned or out-of-range CPU PCs with an error response and performs no memory access for them.

Parameters:
- ADDR_W, 11, word-address width of the instruction memory.
- DATA_W, 32, instruction width.
- MAX_CPU_STREAK, 4, number of consecutive CPU grants while debug waits before debug is forced to win (range 1..15).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cpu_req_valid  in  1  CPU fetch request.
- cpu_req_ready  out  1  CPU request accepted this cycle.
- cpu_req_pc  in  32  byte PC.
- cpu_rsp_valid  out  1  CPU response available.
- cpu_rsp_ready  in  1  CPU consumes the response.
- cpu_rsp_data  out  DATA_W  instruction word; 0 when cpu_rsp_err=1.
- cpu_rsp_err  out  1  misaligned or out-of-range PC.
- dbg_req_valid  in  1  debug read request.
- dbg_req_ready  out  1  debug request accepted.
- dbg_req_addr  in  ADDR_W  word address.
- dbg_rsp_valid  out  1  debug response available.
- dbg_rsp_ready  in  1  debug consumes the response.
- dbg_rsp_data  out  DATA_W  read word.
- mem_en  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_dout  in  DATA_W  memory read data, registered inside the memory.

Behaviour:
- Request handshake occurs when req_valid && req_ready; response handshake occurs when rsp_valid && rsp_ready.
- Pending state: a response is pending (rsp_valid=1 on either port) until its handshake. Define blocked = pending && !(pending response handshakes this cycle).
- Ready rule: no port's req_ready may be 1 while blocked. This keeps mem_dout stable, because mem_en stays low while a response is held.
- Arbitration when not blocked:
  - Default winner is the CPU if cpu_req_valid, otherwise debug.
  - Exception: debug wins if dbg_req_valid && streak >= MAX_CPU_STREAK.
  - Only the winner sees req_ready=1; req_ready may depend combinationally on req_valid.
- Streak counter (4 bits):
  - Increments, saturating, on each CPU grant while dbg_req_valid=1.
  - Clears on a debug grant, or in any cycle with dbg_req_valid=0.
- CPU address check: error if pc[1:0]!=0 or pc[31:ADDR_W+2]!=0; otherwise word address = pc[ADDR_W+1:2].
- Issue cycle N (request handshake):
  - For a debug request or a valid CPU PC: mem_en=1, mem_addr=word address (combinational from the winning request).
  - For an errored CPU PC: mem_en=0.
  - Owner register ← {CPU, DBG}; error flag ← check result.
- Cycle N+1:
  - The owner's rsp_valid=1.
  - rsp_data = mem_dout (combinational pass-through), or 0 with cpu_rsp_err=1 for an errored PC.
  - The other port's rsp_valid=0.
- Latency and throughput:
  - Latency is exactly 1 cycle from request handshake to rsp_valid.
  - Back-to-back throughput is 1 per cycle when the response is consumed each cycle: a new grant may occur in the same cycle as the response handshake.
- Response stall: rsp_valid, rsp_data and rsp_err hold unchanged until rsp_ready.
- Defaults: mem_en=0 whenever there is no grant; mem_addr is don't-care when mem_en=0, but the implementation must drive it to 0.
- Reset (rst_n=0 at a clock edge):
  - Registers: owner/pending cleared, error flag 0, streak 0.
  - Outputs: cpu_rsp_valid=0, dbg_rsp_valid=0, cpu_rsp_err=0, all req_ready=0 during reset, mem_en=0.
  - Reset mid-transaction drops the outstanding response; no response appears after reset.
- Simultaneous requests: exactly one grant per cycle; the losing request must stay valid and is granted later, with no data loss.
- Address boundaries: PC 0x0000_1FFC (word 2047) is valid; PC 0x0000_2000 is an error.

Test Plan:
- Reset, then a CPU request with pc=0x0000_0010 and mem holding 0x2402000A at word 4 → mem_en=1/mem_addr=4 in cycle N; cpu_rsp_valid=1, data 0x2402000A in N+1.
- CPU issues pc 0x0,0x4,0x8 back-to-back with cpu_rsp_ready=1 → three grants on consecutive cycles; responses in N+1..N+3 carry words 0,1,2.
- cpu_rsp_ready=0 for 3 cycles after a response → cpu_rsp_data stays constant, mem_en=0, no req_ready on either port; both resume on the ready cycle.
- cpu_req_valid and dbg_req_valid held continuously, MAX_CPU_STREAK=4 → grant order CPU,CPU,CPU,CPU,DBG,CPU…; dbg_rsp_data equals mem[dbg_req_addr].
- pc=0x0000_0006 and pc=0x0000_2000 → mem_en=0, cpu_rsp_err=1 with data 0 in N+1; pc=0x0000_1FFC → mem_addr=2047, no error.
- rst_n=0 asserted in the cycle after a grant → no rsp_valid appears, streak 0, and the first post-reset grant behaves normally.
